// File: rtl/dct_coef_engine.sv
// Purpose : one 2-D DCT-II coefficient F(k1,k2) of a streamed 8x8 signed pixel block (raster order).
// Latency : coef_valid rises 4 clocks after the edge carrying the 64th pixel handshake.
// Backpr. : pix gaps become pipeline bubbles (no stall); result is held in DONE until coef_ready.
// Ports   : clk, rst_n (async, active-low); start/k1/k2 begin a block from IDLE; busy = not IDLE;
//           pix_data/pix_valid/pix_ready pixel stream; coef/coef_valid/coef_ready result handshake.
module dct_coef_engine #(
    parameter  int PIX_W    = 8,
    parameter  int COS_FRAC = 8,
    localparam int ACC_W    = PIX_W + COS_FRAC + 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [2:0]              k1,
    input  logic [2:0]              k2,
    output logic                    busy,
    input  logic signed [PIX_W-1:0] pix_data,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    output logic signed [ACC_W-1:0] coef,
    output logic                    coef_valid,
    input  logic                    coef_ready
);
    localparam int ROM_W  = COS_FRAC + 1;   // 1.0 needs one integer bit
    localparam int CT_W   = ROM_W + 1;      // signed cosine-product term
    localparam int PROD_W = PIX_W + CT_W;

    // |cos(i*pi/16)| in Q(COS_FRAC), i = 0..8, packed LSB-first; evaluated at elaboration only.
    function automatic logic [9*ROM_W-1:0] build_rom();
        logic [9*ROM_W-1:0] t;
        real                a;
        t = '0;
        for (int i = 0; i < 9; i++) begin
            a = $cos(real'(i) * 3.14159265358979 / 16.0);
            if (a < 0.0) a = -a;
            t[i*ROM_W +: ROM_W] = ROM_W'($rtoi(a * (2.0 ** COS_FRAC)));
        end
        return t;
    endfunction

    localparam logic [9*ROM_W-1:0] ROM_TBL = build_rom();

    // Reduce k*(2n+1) mod 32 onto the first quadrant: returns {negative, idx[3:0]}.
    function automatic logic [4:0] fold(input logic [2:0] k, input logic [2:0] n);
        logic [6:0] p;
        logic [4:0] m;
        p = {4'b0, k} * {3'b0, n, 1'b1};
        m = p[4:0];
        if (m > 5'd16) m = 5'(6'd32 - {1'b0, m});
        if (m > 5'd8) return {1'b1, 4'(5'd16 - m)};
        return {1'b0, m[3:0]};
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t     state, state_nxt;
    logic [6:0] cnt;        // bit 6 set once all 64 pixels have been taken
    logic [1:0] drain_cnt;
    logic [2:0] k1_q, k2_q;
    logic       pix_hs;

    logic                    s0_vld, s0_neg;
    logic [3:0]              s0_idx1, s0_idx2;
    logic signed [PIX_W-1:0] s0_pix;
    logic                    s1_vld;
    logic signed [PIX_W-1:0] s1_pix;
    logic signed [CT_W-1:0]  s1_cos;
    logic                    s2_vld;
    logic signed [PROD_W-1:0] s2_prod;
    logic signed [ACC_W-1:0] acc;

    logic [4:0]              f1, f2;
    logic [ROM_W-1:0]        r1, r2;
    logic [2*ROM_W-1:0]      mag_full;
    logic signed [CT_W-1:0]  ct_mag;
    logic signed [PROD_W-1:0] prod_c;

    assign pix_hs = pix_valid && pix_ready;
    assign coef   = acc;

    // The cycle after the 64th handshake stays in RUN with pix_ready low, then DRAIN
    // runs 3 cycles so the last product lands in acc before DONE.
    always_comb begin
        state_nxt  = state;
        busy       = (state != IDLE);
        pix_ready  = 1'b0;
        coef_valid = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN: begin
                pix_ready = !cnt[6];
                if (cnt[6]) state_nxt = DRAIN;
            end
            DRAIN: if (drain_cnt == 2'd2) state_nxt = DONE;
            DONE: begin
                coef_valid = 1'b1;
                if (coef_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            drain_cnt <= '0;
            k1_q      <= '0;
            k2_q      <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            if (state == IDLE && start) begin
                k1_q <= k1;
                k2_q <= k2;
                cnt  <= '0;
            end else if (pix_hs) begin
                cnt <= cnt + 7'd1;
            end
        end
    end

    // S0 index fold from the raster position of the accepted pixel.
    assign f1 = fold(k1_q, cnt[5:3]);
    assign f2 = fold(k2_q, cnt[2:0]);

    // S1 cosine product: magnitude is truncated before the sign is applied.
    assign r1       = ROM_TBL[s0_idx1*ROM_W +: ROM_W];
    assign r2       = ROM_TBL[s0_idx2*ROM_W +: ROM_W];
    assign mag_full = (2*ROM_W)'(r1) * (2*ROM_W)'(r2);
    assign ct_mag   = {1'b0, ROM_W'(mag_full >> COS_FRAC)};

    // S2 full-width signed product.
    assign prod_c = PROD_W'(s1_pix) * PROD_W'(s1_cos);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_vld  <= 1'b0;
            s0_neg  <= 1'b0;
            s0_idx1 <= '0;
            s0_idx2 <= '0;
            s0_pix  <= '0;
            s1_vld  <= 1'b0;
            s1_pix  <= '0;
            s1_cos  <= '0;
            s2_vld  <= 1'b0;
            s2_prod <= '0;
            acc     <= '0;
        end else begin
            s0_vld  <= pix_hs;
            s0_neg  <= f1[4] ^ f2[4];
            s0_idx1 <= f1[3:0];
            s0_idx2 <= f2[3:0];
            s0_pix  <= pix_data;

            s1_vld  <= s0_vld;
            s1_pix  <= s0_pix;
            s1_cos  <= s0_neg ? -ct_mag : ct_mag;

            s2_vld  <= s1_vld;
            s2_prod <= prod_c;

            if (state == IDLE && start) acc <= '0;
            else if (s2_vld)            acc <= acc + ACC_W'(s2_prod);
        end
    end
endmodule

// File: tb/tb_dct_coef_engine.sv
// Purpose : self-checking bench for dct_coef_engine (table vectors, random blocks vs reference model).
// Latency : checks coef_valid arrives 4 clocks after the last pixel handshake.
// Backpr. : exercises pixel gaps, held coef_ready, start while busy, reset mid-block, back-to-back.
module tb_dct_coef_engine;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [2:0]         k1, k2;
    logic               busy;
    logic signed [7:0]  pix_data;
    logic               pix_valid;
    logic               pix_ready;
    logic signed [23:0] coef;
    logic               coef_valid;
    logic               coef_ready;

    int checks = 0;
    int errors = 0;
    int pix_mem [64];

    localparam real PI = 3.14159265358979;

    always #5 clk = ~clk;

    dct_coef_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k1(k1), .k2(k2), .busy(busy),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .coef(coef), .coef_valid(coef_valid), .coef_ready(coef_ready)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Direct DCT sum: cosine signs from the real angle, magnitudes from the quantised 1-D table.
    function automatic longint model(input int ka, input int kb);
        int     rom [9] = '{256, 251, 236, 212, 181, 142, 97, 49, 0};
        longint sum;
        int     m1, m2, i1, i2, mag;
        bit     neg;
        sum = 0;
        for (int n1 = 0; n1 < 8; n1++) begin
            for (int n2 = 0; n2 < 8; n2++) begin
                m1 = (ka * (2*n1 + 1)) % 32;
                m2 = (kb * (2*n2 + 1)) % 32;
                i1 = m1 % 16; if (i1 > 8) i1 = 16 - i1;
                i2 = m2 % 16; if (i2 > 8) i2 = 16 - i2;
                neg = ($cos(m1 * PI / 16.0) < -1e-6) ^ ($cos(m2 * PI / 16.0) < -1e-6);
                mag = (rom[i1] * rom[i2]) / 256;
                sum += longint'(pix_mem[n1*8 + n2]) * (neg ? -mag : mag);
            end
        end
        return sum;
    endfunction

    // Entered and left on a negedge; inputs change only on negedges.
    task automatic run_block(input int ka, input int kb, input bit gaps, input int hold,
                             input bit poke, input int abort_at, output longint res);
        int  n, cyc, lat;
        bit  v, hs, stable;
        start = 1'b1; k1 = 3'(ka); k2 = 3'(kb);
        @(negedge clk);
        start = 1'b0;
        check("start_accepted", busy, 1);
        n = 0; cyc = 0;
        while (n < 64 && n < abort_at && cyc < 4000) begin
            v = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (poke && n == 10) begin start = 1'b1; k1 = ~k1; k2 = ~k2; end
            else start = 1'b0;
            pix_valid = v;
            pix_data  = 8'(pix_mem[n]);
            hs = v && pix_ready;
            @(negedge clk);
            if (hs) n++;
            cyc++;
        end
        pix_valid = 1'b0;
        start     = 1'b0;
        res = 0;
        if (abort_at < 64) return;
        if (n < 64) begin
            check("pix_timeout", n, 64);
            return;
        end
        lat = 0;
        while (!coef_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("coef_latency", lat, 4);
        res = coef;
        stable = 1'b1;
        coef_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!coef_valid || coef != res) stable = 1'b0;
        end
        if (hold > 0) check("coef_hold_stable", stable, 1);
        coef_ready = 1'b1;
        @(negedge clk);
        coef_ready = 1'b0;
        check("idle_after_handshake", {busy, coef_valid}, 0);
    endtask

    typedef struct {
        string name;
        int    ka, kb;
        int    kind;   // 0: all pixels = val, 1: only pixel (1,0) = val
        int    val;
        longint expv;
    } vec_t;

    initial begin
        vec_t   vecs [5];
        longint r, r_ref, r2;
        int     ka, kb;

        vecs[0] = '{"dc_ones",     0, 0, 0,    1,    16384};
        vecs[1] = '{"dc_neg128",   0, 0, 0, -128, -2097152};
        vecs[2] = '{"symmetry_10", 1, 0, 0,   77,        0};
        vecs[3] = '{"impulse_p1",  3, 2, 1,    1,      -45};
        vecs[4] = '{"impulse_m100",3, 2, 1, -100,     4500};

        rst_n = 1'b0; start = 1'b0; k1 = '0; k2 = '0;
        pix_data = '0; pix_valid = 1'b0; coef_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_coef_valid", coef_valid, 0);
        check("rst_coef", coef, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {busy, pix_ready, coef_valid}, 0);

        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 64; i++)
                pix_mem[i] = (vecs[t].kind == 0 || i == 8) ? vecs[t].val : 0;
            run_block(vecs[t].ka, vecs[t].kb, 1'b0, 0, 1'b0, 64, r);
            check(vecs[t].name, r, vecs[t].expv);
        end

        for (int t = 0; t < 6; t++) begin
            ka = $urandom_range(0, 7); kb = $urandom_range(0, 7);
            for (int i = 0; i < 64; i++) pix_mem[i] = int'($urandom_range(0, 255)) - 128;
            run_block(ka, kb, t[0], 0, 1'b0, 64, r);
            check("random_block", r, model(ka, kb));
        end

        // Same block with and without gaps, held coef_ready and a start pulse while busy.
        for (int i = 0; i < 64; i++) pix_mem[i] = int'($urandom_range(0, 255)) - 128;
        r_ref = model(5, 3);
        run_block(5, 3, 1'b0, 0, 1'b0, 64, r);
        check("bp_gapfree", r, r_ref);
        run_block(5, 3, 1'b1, 10, 1'b1, 64, r2);
        check("bp_gapped_held", r2, r_ref);

        // Reset in the middle of a block, then a clean block with the same k.
        for (int i = 0; i < 64; i++) pix_mem[i] = 127;
        run_block(2, 5, 1'b0, 0, 1'b0, 30, r);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_pix_ready", pix_ready, 0);
        check("abort_coef_valid", coef_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 64; i++) pix_mem[i] = int'($urandom_range(0, 255)) - 128;
        run_block(2, 5, 1'b0, 0, 1'b0, 64, r);
        check("after_abort", r, model(2, 5));

        // Back-to-back: the second start goes in the cycle after the first coef handshake.
        for (int i = 0; i < 64; i++) pix_mem[i] = 3;
        run_block(0, 0, 1'b0, 0, 1'b0, 64, r);
        check("b2b_first", r, 49152);
        for (int i = 0; i < 64; i++) pix_mem[i] = int'($urandom_range(0, 255)) - 128;
        run_block(7, 7, 1'b0, 0, 1'b0, 64, r);
        check("b2b_second", r, model(7, 7));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dct_coef_engine.md
Name: dct_coef_engine

Overview:
- Computes one 2-D DCT-II coefficient F(k1,k2) of an 8x8 pixel block.
- Pixels are streamed in. The (k1,k2) pair is selected at runtime.
- Replaces the family of fixed per-(k1,k2) combinational cosine tables with a single 9-entry 1-D cosine ROM, a runtime cosine-product generator and a pipelined multiply-accumulate.
- Sits between the block buffer and the coefficient quantiser in the FPGA DCT path.

Parameters:
- PIX_W, 8, signed pixel width (two's complement, level-shifted).
- COS_FRAC, 8, fractional bits of the cosine terms.
- ACC_W, PIX_W+COS_FRAC+8, accumulator and coefficient width. Derived; do not override.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a block; sampled only in IDLE
- k1  in  3  row frequency index; latched on start
- k2  in  3  column frequency index; latched on start
- busy  out  1  high in every state except IDLE
- pix_data  in  PIX_W  signed pixel x(n1,n2)
- pix_valid  in  1  pixel valid
- pix_ready  out  1  engine accepts a pixel
- coef  out  ACC_W  signed coefficient, raw Q(COS_FRAC) sum
- coef_valid  out  1  coefficient valid
- coef_ready  in  1  downstream accepts the coefficient

Behaviour:
- Reset:
  - One clock. Reset is asynchronous and active-low.
  - Reset outputs: busy=0, pix_ready=0, coef_valid=0, coef=0. State=IDLE. Counter, pipeline valids and accumulator cleared.
  - Reset asserted mid-block aborts the block; no partial result is ever emitted.
- FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
  - IDLE, start=1: latch k1 and k2, clear the accumulator, set pixel counter=0, go to RUN.
  - RUN: pix_ready=1. A handshake (pix_valid & pix_ready) feeds stage 0 and increments the counter. After the 64th handshake, go to DRAIN the next cycle with pix_ready=0.
  - DRAIN: exactly 3 cycles, flushing the pipeline. Then go to DONE.
  - DONE: coef_valid=1 and coef held stable. On coef_ready=1, return to IDLE; a new start is accepted from the following cycle.
- start outside IDLE is ignored.
- pix_valid gaps in RUN insert bubbles; each stage carries a valid bit. There is no stall logic.
- Pixel order is raster: counter[5:3]=n1, counter[2:0]=n2 (n2 fastest).
- Pipeline:
  - S0: m1=(k1*(2*n1+1)) mod 32 and m2=(k2*(2*n2+1)) mod 32. Fold each index: if m>16 then m=32-m; if m>8 then idx=16-m and the sign is negative, else idx=m. The product sign is the XOR of the two signs.
  - S1: ROM entry ROM[i]=floor(|cos(i*pi/16)|*2^COS_FRAC), i=0..8. Entries are built by an elaboration-time constant function. For COS_FRAC=8: 256, 251, 236, 212, 181, 142, 97, 49, 0.
  - S1 cos term: |cos_term|=(ROM[idx1]*ROM[idx2])>>COS_FRAC, truncated; then apply the sign, so a term and its negation have identical magnitude.
  - S2: prod = pix_data * cos_term, full signed width.
  - S3: acc += prod, sign-extended to ACC_W.
- Latency: coef_valid rises 4 cycles after the clock edge of the 64th pixel handshake.
- Arithmetic never overflows: |coef| <= 2^(PIX_W-1)*2^COS_FRAC*64 < 2^(ACC_W-1).

Test Plan:
- Reset mid-RUN: assert rst_n=0 after 30 pixels -> busy=0, pix_ready=0, coef_valid=0 immediately. Next start -> clean block result with no residue from the aborted one.
- DC term: k=(0,0), all 64 pixels=1 -> coef=16384. All pixels=-128 -> coef=-2097152.
- Symmetry: k=(1,0), all pixels=77 -> coef=0 exactly.
- Impulse: k=(3,2), pixel(1,0)=1, all others 0 -> cos_term=-(49*236>>8)=-45, so coef=-45. Same with pixel value -100 -> coef=4500.
- Backpressure: random pix_valid gaps (50% duty) and coef_ready held low 10 cycles -> same coef as the gap-free run. coef stays stable while held; start is ignored while busy.
- Back-to-back: two blocks, k=(0,0) then k=(7,7), with start asserted the cycle after the first coef handshake -> both results correct; the second start is accepted.
